// File: rtl/inst_trace_buffer.sv
// Commit trace FIFO: captures {seq, pc, inst} per retired instruction and drains over valid/ready.
// Optional pc-window filter enabled by defining TRACE_PC_FILTER_EN.
module inst_trace_buffer #(
  parameter int DEPTH    = 16,
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int SEQ_LEN  = 16,
  parameter int DROP_LEN = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        commit,
  input  logic [ADDR_LEN-1:0]         pc_in,
  input  logic [DATA_LEN-1:0]         inst_in,
`ifdef TRACE_PC_FILTER_EN
  input  logic [ADDR_LEN-1:0]         filt_lo,
  input  logic [ADDR_LEN-1:0]         filt_hi,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SEQ_LEN-1:0]          out_seq,
  output logic [ADDR_LEN-1:0]         out_pc,
  output logic [DATA_LEN-1:0]         out_inst,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic [DROP_LEN-1:0]         drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [SEQ_LEN-1:0]  seq_mem  [DEPTH];
  logic [ADDR_LEN-1:0] pc_mem   [DEPTH];
  logic [DATA_LEN-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [SEQ_LEN-1:0] seq_cnt;

  logic empty;
  logic in_range;
  logic pop;
  logic attempt;
  logic accept;
  logic drop;

`ifdef TRACE_PC_FILTER_EN
  assign in_range = (pc_in >= filt_lo) && (pc_in <= filt_hi);
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    pop     = !empty && out_ready;
    attempt = commit && in_range;
    // A full buffer still takes the push when the head leaves on the same edge
    accept  = attempt && (!full || pop);
    drop    = attempt && !accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (commit)
        seq_cnt <= seq_cnt + 1'b1;
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(accept) - CNT_W'(pop);
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      seq_mem[wr_ptr]  <= seq_cnt;
      pc_mem[wr_ptr]   <= pc_in;
      inst_mem[wr_ptr] <= inst_in;
    end
  end

  assign out_valid = !empty;
  assign out_seq   = empty ? '0 : seq_mem[rd_ptr];
  assign out_pc    = empty ? '0 : pc_mem[rd_ptr];
  assign out_inst  = empty ? '0 : inst_mem[rd_ptr];

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Bench for inst_trace_buffer: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_inst_trace_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_seq;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;
  logic        full;
  logic [15:0] drop_cnt;
`ifdef TRACE_PC_FILTER_EN
  logic [31:0] filt_lo = 32'h10;
  logic [31:0] filt_hi = 32'h1C;
`endif

  inst_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .commit(commit),
    .pc_in(pc_in),
    .inst_in(inst_in),
`ifdef TRACE_PC_FILTER_EN
    .filt_lo(filt_lo),
    .filt_hi(filt_hi),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_seq(out_seq),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .count(count),
    .full(full),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [79:0] mq[$];
  logic [15:0] m_seq;
  logic [15:0] m_drop;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_in_range(input logic [31:0] p);
`ifdef TRACE_PC_FILTER_EN
    return (p >= filt_lo) && (p <= filt_hi);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_all();
    logic [79:0] h;
    h = (mq.size() != 0) ? mq[0] : 80'h0;
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("count", 64'(count), 64'(mq.size()));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("out_seq", 64'(out_seq), 64'(h[79:64]));
    chk("out_pc", 64'(out_pc), 64'(h[63:32]));
    chk("out_inst", 64'(out_inst), 64'(h[31:0]));
  endtask

  // Check the state left by the previous edge, then drive this cycle
  // and advance the model to what the next edge should produce.
  task automatic step(input logic c, input logic [31:0] p,
                      input logic [31:0] i, input logic r,
                      input logic rs);
    bit do_pop;
    bit att;
    bit acc;
    @(negedge clk);
    check_all();
    commit    = c;
    pc_in     = p;
    inst_in   = i;
    out_ready = r;
    rst       = rs;
    if (rs) begin
      mq.delete();
      m_seq  = '0;
      m_drop = '0;
    end else begin
      do_pop = (mq.size() != 0) && r;
      att    = c && m_in_range(p);
      acc    = att && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (acc) mq.push_back({m_seq, p, i});
      else if (att && m_drop != 16'hFFFF) m_drop++;
      if (c) m_seq++;
    end
  endtask

  initial begin
    rst = 1'b1;
    commit = 1'b0;
    pc_in = '0;
    inst_in = '0;
    out_ready = 1'b0;
    mq.delete();
    m_seq = '0;
    m_drop = '0;
    repeat (2) @(posedge clk);

    // reset then idle
    repeat (5) step(0, 0, 0, 0, 0);
    chk("idle_pc", 64'(out_pc), 64'h0);

    // three commits then drain
    step(1, 32'h00, 32'h20080005, 0, 0);
    step(1, 32'h04, 32'h20090003, 0, 0);
    step(1, 32'h08, 32'h01095020, 0, 0);
    repeat (4) step(0, 0, 0, 1, 0);

    // overflow: six commits with consumer stalled
    for (int k = 0; k < 6; k++)
      step(1, 32'(k * 4), 32'hA000_0000 + 32'(k), 0, 0);
    step(0, 0, 0, 0, 0);
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    repeat (5) step(0, 0, 0, 1, 0);
    step(1, 32'h18, 32'hB000_0018, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("seq_gap", 64'(out_seq), 64'(16'(m_seq - 1'b1)));

    // full with simultaneous pop and push, then drain across wrap
    for (int k = 0; k < 3; k++)
      step(1, 32'h100 + 32'(k * 4), 32'hC000_0000 + 32'(k), 0, 0);
    for (int k = 0; k < 4; k++)
      step(1, 32'h200 + 32'(k * 4), 32'hD000_0000 + 32'(k), 1, 0);
    for (int k = 0; k < 4; k++)
      step(1, 32'h300 + 32'(k * 4), 32'hE000_0000 + 32'(k), 1, 0);
    repeat (6) step(0, 0, 0, 1, 0);

    // empty with commit and ready together
    step(1, 32'h40, 32'h1234_5678, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 32'h44, 32'h1, 0, 0);
    step(1, 32'h48, 32'h2, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 32'h4C, 32'h3, 1, 1);
    step(1, 32'h50, 32'h4, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("seq_restart", 64'(out_seq), 64'h0);

    // filter window corners
    step(1, 32'h0C, 32'h5, 0, 1);
    step(1, 32'h0C, 32'h6, 0, 0);
    step(1, 32'h10, 32'h7, 0, 0);
    step(1, 32'h1C, 32'h8, 0, 0);
    step(1, 32'h20, 32'h9, 0, 0);
    repeat (4) step(0, 0, 0, 1, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) < 60),
           32'($urandom_range(0, 15) * 4),
           $urandom,
           ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 499) == 0));
    end
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
